mem_arbiter: RTL and testbench

Single-port memory arbiter between the Z80 core bus and the 64 KB system RAM, with a second read-only port for the video fetcher. Both requesters are served through one synchronous RAM with one-cycle read latency. Each access runs through a fixed four-state sequence. A stall counter keeps continuous video fetches from starving the CPU indefinitely.

---
 rtl/mem_arbiter.sv | 107 ++++++++++
 tb/tb_mem_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous 64 KB RAM between the Z80 bus and a
// read-only video fetcher, one access per IDLE/ACCESS/DONE/ACK sequence.
module mem_arbiter #(
    parameter int STALL_MAX = 3
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        cpu_req,
    input  logic [15:0] cpu_address,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_we,
    output logic [7:0]  cpu_din,
    output logic        cpu_ready,
    input  logic        vid_req,
    input  logic [15:0] vid_address,
    output logic [7:0]  vid_data,
    output logic        vid_ack,
    output logic [15:0] ram_address,
    output logic [7:0]  ram_wdata,
    output logic        ram_we,
    input  logic [7:0]  ram_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE,
        ACK
    } state_t;

    localparam logic [2:0] STALL_LIM = 3'(STALL_MAX);

    state_t     state;
    logic       owner;
    logic       write;
    logic [2:0] stall_cnt;
    logic       cpu_win;

    // Video wins a tie until the CPU has been passed over STALL_MAX times.
    always_comb begin
        cpu_win = cpu_req && (!vid_req || stall_cnt >= STALL_LIM);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= IDLE;
            owner       <= 1'b0;
            write       <= 1'b0;
            stall_cnt   <= 3'd0;
            ram_address <= 16'h0000;
            ram_wdata   <= 8'h00;
            ram_we      <= 1'b0;
            cpu_din     <= 8'h00;
            vid_data    <= 8'h00;
            cpu_ready   <= 1'b0;
            vid_ack     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_win) begin
                        owner       <= 1'b0;
                        write       <= cpu_we;
                        ram_address <= cpu_address;
                        ram_wdata   <= cpu_dout;
                        ram_we      <= cpu_we;
                        stall_cnt   <= 3'd0;
                        state       <= ACCESS;
                    end else if (vid_req) begin
                        owner       <= 1'b1;
                        write       <= 1'b0;
                        ram_address <= vid_address;
                        ram_we      <= 1'b0;
                        if (cpu_req && stall_cnt < STALL_LIM) begin
                            stall_cnt <= stall_cnt + 3'd1;
                        end
                        state       <= ACCESS;
                    end
                end
                ACCESS: begin
                    ram_we <= 1'b0;
                    state  <= DONE;
                end
                DONE: begin
                    if (owner) begin
                        vid_data <= ram_rdata;
                        vid_ack  <= 1'b1;
                    end else begin
                        if (!write) begin
                            cpu_din <= ram_rdata;
                        end
                        cpu_ready <= 1'b1;
                    end
                    state <= ACK;
                end
                ACK: begin
                    cpu_ready <= 1'b0;
                    vid_ack   <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: transaction-level reference model with a queue scoreboard,
// directed test-plan scenarios followed by randomized CPU/video traffic.
module tb_mem_arbiter;

    localparam int STALL_MAX = 3;

    logic        clock;
    logic        reset_n;
    logic        cpu_req;
    logic [15:0] cpu_address;
    logic [7:0]  cpu_dout;
    logic        cpu_we;
    logic [7:0]  cpu_din;
    logic        cpu_ready;
    logic        vid_req;
    logic [15:0] vid_address;
    logic [7:0]  vid_data;
    logic        vid_ack;
    logic [15:0] ram_address;
    logic [7:0]  ram_wdata;
    logic        ram_we;
    logic [7:0]  ram_rdata;

    mem_arbiter #(.STALL_MAX(STALL_MAX)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .cpu_req    (cpu_req),
        .cpu_address(cpu_address),
        .cpu_dout   (cpu_dout),
        .cpu_we     (cpu_we),
        .cpu_din    (cpu_din),
        .cpu_ready  (cpu_ready),
        .vid_req    (vid_req),
        .vid_address(vid_address),
        .vid_data   (vid_data),
        .vid_ack    (vid_ack),
        .ram_address(ram_address),
        .ram_wdata  (ram_wdata),
        .ram_we     (ram_we),
        .ram_rdata  (ram_rdata)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        bit         vid;
        bit         we;
        logic [7:0] data;
        int         ack_cyc;
    } exp_t;

    int   total = 0;
    int   bad = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    task automatic check(input bit ok, input string name,
                         input logic [31:0] act, input logic [31:0] want);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at cycle %0d", name, act, want, cyc);
        end
    endtask

    function automatic logic [7:0] init_byte(input int a);
        case (a)
            'h1234:  return 8'hA5;
            'h4000:  return 8'h11;
            'h0100:  return 8'h22;
            'h0000:  return 8'h77;
            default: return 8'(a ^ (a >> 8) ^ 'h3C);
        endcase
    endfunction

    // Synchronous RAM, one-cycle read latency.
    logic [7:0] ram [0:65535];
    bit         ram_loaded = 0;
    always @(posedge clock) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 65536; i++) ram[i] <= init_byte(i);
            ram_loaded = 1;
        end else if (ram_we) begin
            ram[ram_address] <= ram_wdata;
        end
        ram_rdata <= ram[ram_address];
    end

    // Reference model: one access occupies four cycles; a tie goes to video
    // unless the CPU has already been passed over STALL_MAX times.
    logic [7:0]  shadow [0:65535];
    bit          sh_loaded = 0;
    int          cyc = 0;
    int          busy = 0;
    int          cpu_wait = 0;
    logic [15:0] m_addr = 16'h0000;
    logic [7:0]  m_wdata = 8'h00;
    int          m_we_cyc = -1;
    bit          mon_en = 0;
    exp_t        ge;

    always @(posedge clock) begin
        cyc++;
        if (!sh_loaded) begin
            for (int i = 0; i < 65536; i++) shadow[i] = init_byte(i);
            sh_loaded = 1;
        end
        if (!reset_n) begin
            busy = 0;
            cpu_wait = 0;
            m_addr = 16'h0000;
            m_wdata = 8'h00;
            m_we_cyc = -1;
            exp_q.delete();
            mon_en = 1;
        end else if (busy > 0) begin
            busy--;
        end else if (cpu_req || vid_req) begin
            if (cpu_req && (!vid_req || cpu_wait == STALL_MAX)) begin
                cpu_wait = 0;
                ge.vid = 0;
                ge.we = cpu_we;
                m_addr = cpu_address;
                if (cpu_we) begin
                    m_wdata = cpu_dout;
                    m_we_cyc = cyc;
                    shadow[cpu_address] = cpu_dout;
                end
            end else begin
                if (cpu_req) cpu_wait++;
                ge.vid = 1;
                ge.we = 0;
                m_addr = vid_address;
            end
            ge.data = shadow[m_addr];
            ge.ack_cyc = cyc + 2;
            exp_q.push_back(ge);
            busy = 3;
        end
    end

    int cpu_acks = 0;
    int vid_acks = 0;
    int last_cpu_ack = 0;
    int last_vid_ack = 0;

    always @(negedge clock) begin
        if (mon_en) begin
            check(!(cpu_ready && vid_ack), "one_ack", {cpu_ready, vid_ack}, 0);
            check(ram_address === m_addr, "ram_address", ram_address, m_addr);
            check(ram_we === (cyc == m_we_cyc), "ram_we", ram_we, cyc == m_we_cyc);
            if (cyc == m_we_cyc) begin
                check(ram_wdata === m_wdata, "ram_wdata", ram_wdata, m_wdata);
            end
            if (exp_q.size() > 0 && exp_q[0].ack_cyc < cyc) begin
                check(0, "missing_ack", 0, 1);
                void'(exp_q.pop_front());
            end
            if (cpu_ready === 1'b1 || vid_ack === 1'b1) begin
                if (vid_ack) begin
                    vid_acks++;
                    last_vid_ack = cyc;
                end else begin
                    cpu_acks++;
                    last_cpu_ack = cyc;
                end
                if (exp_q.size() == 0) begin
                    check(0, "unexpected_ack", {cpu_ready, vid_ack}, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check(vid_ack == mon_e.vid, "ack_owner", vid_ack, mon_e.vid);
                    check(cyc == mon_e.ack_cyc, "ack_cycle", cyc, mon_e.ack_cyc);
                    if (!mon_e.we && mon_e.vid) begin
                        check(vid_data === mon_e.data, "vid_data", vid_data, mon_e.data);
                    end else if (!mon_e.we) begin
                        check(cpu_din === mon_e.data, "cpu_din", cpu_din, mon_e.data);
                    end
                end
            end
        end
    end

    task automatic cpu_access(input logic [15:0] a, input logic we, input logic [7:0] d);
        bit got = 0;
        cpu_address = a;
        cpu_we = we;
        cpu_dout = d;
        cpu_req = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clock);
            got = cpu_ready;
        end
        check(got, "cpu_done", got, 1);
        cpu_req = 1'b0;
    endtask

    task automatic vid_burst(input int n, input logic [15:0] base);
        bit got;
        vid_req = 1'b1;
        for (int k = 0; k < n; k++) begin
            vid_address = base + 16'(k);
            got = 0;
            for (int i = 0; i < 40 && !got; i++) begin
                @(negedge clock);
                got = vid_ack;
            end
            check(got, "vid_done", got, 1);
        end
        vid_req = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check(ram_address === 16'h0, {tag, "_ram_address"}, ram_address, 0);
        check(ram_wdata === 8'h0, {tag, "_ram_wdata"}, ram_wdata, 0);
        check(ram_we === 1'b0, {tag, "_ram_we"}, ram_we, 0);
        check(cpu_din === 8'h0, {tag, "_cpu_din"}, cpu_din, 0);
        check(vid_data === 8'h0, {tag, "_vid_data"}, vid_data, 0);
        check(cpu_ready === 1'b0, {tag, "_cpu_ready"}, cpu_ready, 0);
        check(vid_ack === 1'b0, {tag, "_vid_ack"}, vid_ack, 0);
    endtask

    initial begin
        repeat (20000) @(posedge clock);
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    int nv1, nv2, v0, n0;

    initial begin
        reset_n = 1'b0;
        cpu_req = 1'b0;
        cpu_address = 16'h0;
        cpu_dout = 8'h0;
        cpu_we = 1'b0;
        vid_req = 1'b0;
        vid_address = 16'h0;
        repeat (3) @(negedge clock);
        check_zero("reset");
        reset_n = 1'b1;
        @(negedge clock);

        cpu_access(16'h1234, 1'b0, 8'h00);
        check(cpu_din === 8'hA5, "rd_1234", cpu_din, 8'hA5);
        cpu_access(16'h8000, 1'b1, 8'h5A);
        cpu_access(16'h8000, 1'b0, 8'h00);
        check(cpu_din === 8'h5A, "rd_8000", cpu_din, 8'h5A);
        cpu_access(16'hFFFF, 1'b1, 8'hC3);
        cpu_access(16'hFFFF, 1'b0, 8'h00);
        check(cpu_din === 8'hC3, "rd_ffff", cpu_din, 8'hC3);
        cpu_access(16'h0000, 1'b0, 8'h00);
        check(cpu_din === 8'h77, "rd_0000", cpu_din, 8'h77);

        @(negedge clock);
        fork
            cpu_access(16'h0100, 1'b0, 8'h00);
            vid_burst(1, 16'h4000);
        join
        @(negedge clock);
        check(vid_data === 8'h11, "tie_vid", vid_data, 8'h11);
        check(cpu_din === 8'h22, "tie_cpu", cpu_din, 8'h22);
        check(last_cpu_ack - last_vid_ack == 4, "tie_gap", last_cpu_ack - last_vid_ack, 4);

        v0 = vid_acks;
        fork
            begin
                cpu_access(16'h0100, 1'b0, 8'h00);
                nv1 = vid_acks - v0;
                v0 = vid_acks;
                cpu_access(16'h1234, 1'b0, 8'h00);
                nv2 = vid_acks - v0;
            end
            vid_burst(8, 16'h4000);
        join
        check(nv1 == STALL_MAX, "starve_1", nv1, STALL_MAX);
        check(nv2 == STALL_MAX, "starve_2", nv2, STALL_MAX);

        fork
            for (int i = 0; i < 30; i++) begin
                repeat ($urandom_range(0, 3)) @(negedge clock);
                cpu_access(16'h2000 + 16'($urandom_range(0, 15)),
                           1'($urandom_range(0, 1)), 8'($urandom));
            end
            for (int i = 0; i < 40; i++) begin
                repeat ($urandom_range(0, 3)) @(negedge clock);
                vid_burst(1, 16'h2000 + 16'($urandom_range(0, 15)));
            end
        join

        repeat (2) @(negedge clock);
        cpu_address = 16'h0100;
        cpu_we = 1'b0;
        cpu_req = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        cpu_req = 1'b0;
        @(negedge clock);
        check_zero("midreset");
        reset_n = 1'b1;
        @(negedge clock);
        cpu_access(16'h0100, 1'b0, 8'h00);
        check(cpu_din === 8'h22, "post_reset", cpu_din, 8'h22);

        @(negedge clock);
        n0 = cpu_acks + vid_acks;
        repeat (20) @(negedge clock);
        check(cpu_acks + vid_acks == n0, "idle_acks", cpu_acks + vid_acks, n0);

        repeat (8) @(negedge clock);
        check(exp_q.size() == 0, "drain", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
